// File: rtl/multicycle_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared encodings for the RV32I multicycle controller:
//                opcodes, immediate formats, ALU operations, writeback
//                sources and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // FSM states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Supported major opcodes (IR[6:0])
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Immediate sign-extension formats
    localparam logic [2:0] I_SEXT = 3'd0;
    localparam logic [2:0] S_SEXT = 3'd1;
    localparam logic [2:0] B_SEXT = 3'd2;
    localparam logic [2:0] U_SEXT = 3'd3;
    localparam logic [2:0] J_SEXT = 3'd4;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_NOOP = 4'd15;

    // Writeback sources
    localparam logic [1:0] FROM_ALU = 2'd0;
    localparam logic [1:0] FROM_DM  = 2'd1;
    localparam logic [1:0] PC4      = 2'd2;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI: is_legal_op = 1'b1;
            default:                                                 is_legal_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_alu_dec
//  Description : Combinational ALU-operation decoder. Maps opcode, funct3
//                and funct7[5] to the ALU operation code.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] aluSel_o
);

    // Only funct7[5] distinguishes SUB/SRA from ADD/SRL in RV32I
    logic w_unused_f7;
    assign w_unused_f7 = ^{funct7_i[6], funct7_i[4:0]};

    // Operation select; funct7[5] only turns ADD into SUB for register-register ops
    always_comb begin
        aluSel_o = ALU_NOOP;
        if (opcode_i == OP_R || opcode_i == OP_I) begin
            case (funct3_i)
                3'b000: aluSel_o = (opcode_i == OP_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                3'b001: aluSel_o = ALU_SLL;
                3'b010: aluSel_o = ALU_SLT;
                3'b011: aluSel_o = ALU_SLTU;
                3'b100: aluSel_o = ALU_XOR;
                3'b101: aluSel_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                3'b110: aluSel_o = ALU_OR;
                3'b111: aluSel_o = ALU_AND;
                default: aluSel_o = ALU_NOOP;
            endcase
        end else if (opcode_i == OP_LW || opcode_i == OP_S || opcode_i == OP_B ||
                     opcode_i == OP_JAL || opcode_i == OP_JALR) begin
            aluSel_o = ALU_ADD;
        end else if (opcode_i == OP_LUI) begin
            aluSel_o = ALU_LUI;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : RV32I multicycle controller. Sequences FETCH/DECODE/EXEC/
//                MEM/WB, drives memory handshakes, register strobes and
//                datapath selects, counts retired instructions and traps on
//                illegal opcodes or memory handshake timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic             brAns_i,
    input  logic             haltReq_i,
    input  logic             imemReady_i,
    input  logic             dmemReady_i,
    output logic             imemReq_o,
    output logic             dmemReq_o,
    output logic             memRW_o,
    output logic             irWEn_o,
    output logic             abWEn_o,
    output logic             aluOutWEn_o,
    output logic             mdrWEn_o,
    output logic             regWEn_o,
    output logic             pcWEn_o,
    output logic             pcSel_o,
    output logic [2:0]       immSel_o,
    output logic             aSel_o,
    output logic             bSel_o,
    output logic [3:0]       aluSel_o,
    output logic [2:0]       brOp_o,
    output logic [1:0]       wbSel_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o,
    output logic             timeout_o
);

    // Last wait-counter value before a handshake is declared dead
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t           state_q;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             illegal_q;
    logic             timeout_q;
    logic             start_q;     // first FETCH cycle after reset release

    logic             w_is_lw;
    logic             w_is_s;
    logic             w_is_b;
    logic             w_is_jump;
    logic             w_in_instr;
    logic [3:0]       w_alu_op;

    assign w_is_lw    = (opcode_i == OP_LW);
    assign w_is_s     = (opcode_i == OP_S);
    assign w_is_b     = (opcode_i == OP_B);
    assign w_is_jump  = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
    assign w_in_instr = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM)    || (state_q == ST_WB);
    assign instret_d  = instret_q + CNT_W'(1);

    multicycle_ctrl_alu_dec u_alu_dec (
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .aluSel_o (w_alu_op)
    );

    // Sequencer: state, handshake wait counter, retire counter and sticky traps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= 8'd0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            start_q <= 1'b0;
            if (pcWEn_o) begin
                instret_q <= instret_d;
            end
            case (state_q)
                ST_FETCH: begin
                    if (start_q && haltReq_i) begin
                        state_q <= ST_HALT;
                    end else if (imemReady_i) begin
                        state_q <= ST_DECODE;
                    end else if (wait_q == LAST_WAIT) begin
                        state_q   <= ST_TRAP;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (is_legal_op(opcode_i)) begin
                        state_q <= ST_EXEC;
                    end else begin
                        state_q   <= ST_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_is_lw || w_is_s) begin
                        state_q <= ST_MEM;
                        wait_q  <= 8'd0;
                    end else if (w_is_b) begin
                        state_q <= haltReq_i ? ST_HALT : ST_FETCH;
                        wait_q  <= 8'd0;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmemReady_i) begin
                        if (w_is_s) begin
                            state_q <= haltReq_i ? ST_HALT : ST_FETCH;
                            wait_q  <= 8'd0;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (wait_q == LAST_WAIT) begin
                        state_q   <= ST_TRAP;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ST_WB: begin
                    state_q <= haltReq_i ? ST_HALT : ST_FETCH;
                    wait_q  <= 8'd0;
                end
                ST_HALT: begin
                    if (!haltReq_i) begin
                        state_q <= ST_FETCH;
                        wait_q  <= 8'd0;
                    end
                end
                default: begin
                    state_q <= ST_TRAP;
                end
            endcase
        end
    end

    // Per-state strobes and handshake requests; FETCH is gated by rst_n so nothing leaks in reset
    always_comb begin
        imemReq_o   = 1'b0;
        dmemReq_o   = 1'b0;
        memRW_o     = 1'b0;
        irWEn_o     = 1'b0;
        abWEn_o     = 1'b0;
        aluOutWEn_o = 1'b0;
        mdrWEn_o    = 1'b0;
        regWEn_o    = 1'b0;
        pcWEn_o     = 1'b0;
        pcSel_o     = 1'b0;
        wbSel_o     = FROM_ALU;
        case (state_q)
            ST_FETCH: begin
                if (rst_n && !(start_q && haltReq_i)) begin
                    imemReq_o = 1'b1;
                    irWEn_o   = imemReady_i;
                end
            end
            ST_DECODE: begin
                abWEn_o = 1'b1;
            end
            ST_EXEC: begin
                aluOutWEn_o = 1'b1;
                if (w_is_b) begin
                    // Taken branch selects the ALU target (pcSel=0)
                    pcWEn_o = 1'b1;
                    pcSel_o = ~brAns_i;
                end
            end
            ST_MEM: begin
                dmemReq_o = 1'b1;
                memRW_o   = w_is_s;
                if (dmemReady_i) begin
                    if (w_is_s) begin
                        pcWEn_o = 1'b1;
                        pcSel_o = 1'b1;
                    end else begin
                        mdrWEn_o = 1'b1;
                    end
                end
            end
            ST_WB: begin
                regWEn_o = 1'b1;
                pcWEn_o  = 1'b1;
                pcSel_o  = ~w_is_jump;
                if (w_is_jump) begin
                    wbSel_o = PC4;
                end else if (w_is_lw) begin
                    wbSel_o = FROM_DM;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath selects follow the opcode while an instruction is in flight, zero otherwise
    always_comb begin
        immSel_o = I_SEXT;
        aSel_o   = 1'b0;
        bSel_o   = 1'b0;
        brOp_o   = 3'b111;
        aluSel_o = w_alu_op;
        case (opcode_i)
            OP_R:         aSel_o = 1'b1;
            OP_I, OP_LW:  begin aSel_o = 1'b1; bSel_o = 1'b1; end
            OP_S:         begin immSel_o = S_SEXT; aSel_o = 1'b1; bSel_o = 1'b1; end
            OP_B:         begin immSel_o = B_SEXT; bSel_o = 1'b1; brOp_o = funct3_i; end
            OP_JAL:       begin immSel_o = J_SEXT; bSel_o = 1'b1; end
            OP_JALR:      begin aSel_o = 1'b1; bSel_o = 1'b1; end
            OP_LUI:       begin immSel_o = U_SEXT; bSel_o = 1'b1; end
            default:      begin end
        endcase
        if (!w_in_instr) begin
            immSel_o = 3'd0;
            aSel_o   = 1'b0;
            bSel_o   = 1'b0;
            brOp_o   = 3'd0;
            aluSel_o = 4'd0;
        end
    end

    assign state_o   = state_q;
    assign instret_o = instret_q;
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;

endmodule
`default_nettype wire
